// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signal bundle for the load/store unit.
// The unit takes the slave view; the core and memory together take the master view.
interface load_store_unit_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [2:0]  REQ_FUNCT3;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic [31:0] RSP_DATA;
  logic        RSP_ERR;
  logic        MEM_WE;
  logic [31:0] MEM_A;
  logic [31:0] MEM_WD;
  logic [31:0] MEM_RD;

  modport master (
    output REQ_VALID, REQ_WE, REQ_FUNCT3, REQ_ADDR, REQ_WDATA, MEM_RD,
    input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR, MEM_WE, MEM_A, MEM_WD
  );

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_FUNCT3, REQ_ADDR, REQ_WDATA, MEM_RD,
    output REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR, MEM_WE, MEM_A, MEM_WD
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit for a word-wide memory: extracts and extends load lanes,
// builds SB/SH as read-then-write, and rejects misaligned/illegal/out-of-range requests.
module load_store_unit #(
  parameter int unsigned MEM_IDX_W   = 5,
  parameter bit          CHECK_RANGE = 1'b1
) (
  input logic               CLK,
  input logic               RST,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StWrite, StResp} state_e;

  state_e      state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_q;
  logic [15:0] wdata_q;
  logic        ready_q, rsp_valid_q, rsp_err_q, mem_we_q;
  logic [31:0] rsp_data_q, mem_a_q, mem_wd_q;

  logic        req_err, fn_bad, misalign, range_bad;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val, merged;

  // Request legality, evaluated on the live request so errors skip the memory cycle.
  always_comb begin
    fn_bad    = 1'b0;
    misalign  = 1'b0;
    range_bad = 1'b0;
    case ({bus.REQ_WE, bus.REQ_FUNCT3})
      4'b0_000, 4'b0_100, 4'b1_000: misalign = 1'b0;
      4'b0_001, 4'b0_101, 4'b1_001: misalign = bus.REQ_ADDR[0];
      4'b0_010, 4'b1_010:           misalign = |bus.REQ_ADDR[1:0];
      default:                      fn_bad   = 1'b1;
    endcase
    if (CHECK_RANGE) range_bad = |bus.REQ_ADDR[31:MEM_IDX_W+2];
    req_err = fn_bad | misalign | range_bad;
  end

  always_comb begin
    rd_byte = bus.MEM_RD[{addr_q, 3'b000} +: 8];
    rd_half = addr_q[1] ? bus.MEM_RD[31:16] : bus.MEM_RD[15:0];
    case (funct3_q)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_val = {24'h0, rd_byte};
      3'b101:  load_val = {16'h0, rd_half};
      default: load_val = bus.MEM_RD;
    endcase
    merged = bus.MEM_RD;
    if (funct3_q[0]) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    else             merged[{addr_q, 3'b000} +: 8]      = wdata_q[7:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= 2'b00;
      wdata_q     <= 16'h0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 32'h0;
      mem_we_q    <= 1'b0;
      mem_a_q     <= 32'h0;
      mem_wd_q    <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.REQ_VALID) begin
            we_q     <= bus.REQ_WE;
            funct3_q <= bus.REQ_FUNCT3;
            addr_q   <= bus.REQ_ADDR[1:0];
            wdata_q  <= bus.REQ_WDATA[15:0];
            ready_q  <= 1'b0;
            if (req_err) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= 32'h0;
            end else begin
              // Memory outputs are registered, so the access cycle is set up here.
              state_q  <= StAccess;
              mem_a_q  <= {2'b00, bus.REQ_ADDR[31:2]};
              mem_we_q <= bus.REQ_WE && (bus.REQ_FUNCT3 == 3'b010);
              if (bus.REQ_WE) mem_wd_q <= bus.REQ_WDATA;
            end
          end
        end
        StAccess: begin
          if (we_q && funct3_q != 3'b010) begin
            state_q  <= StWrite;
            mem_we_q <= 1'b1;
            mem_wd_q <= merged;
          end else begin
            state_q     <= StResp;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= we_q ? 32'h0 : load_val;
          end
        end
        StWrite: begin
          state_q     <= StResp;
          mem_we_q    <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= 32'h0;
        end
        StResp: begin
          state_q     <= StIdle;
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.REQ_READY = ready_q;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_DATA  = rsp_data_q;
  assign bus.RSP_ERR   = rsp_err_q;
  assign bus.MEM_WE    = mem_we_q;
  assign bus.MEM_A     = mem_a_q;
  assign bus.MEM_WD    = mem_wd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a request-level model predicts responses, memory
// writes and readiness per cycle; literal checks pin the model on the key vectors.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_IDX_W(5), .CHECK_RANGE(1'b1)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // Data memory owned by the bench, combinational read.
  logic [31:0] mem [32];
  assign bus.MEM_RD = mem[bus.MEM_A[4:0]];
  always @(posedge clk) if (bus.MEM_WE) mem[bus.MEM_A[4:0]] <= bus.MEM_WD;

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {int unsigned cyc; logic [31:0] data; logic err;} rsp_t;
  typedef struct {int unsigned cyc; logic [31:0] a; logic [31:0] d;} wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  wr_t  cm_q[$];
  logic [31:0] sh [32];
  int unsigned cyc = 0;       // index of the most recent rising edge
  int unsigned ready_at = 0;  // unit ready in cycles after edge >= ready_at
  int unsigned acc_edge = 0;
  bit          chk_on = 1'b0;

  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] b, h;
    w = sh[a[6:2]];
    b = (w >> (8 * a[1:0])) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b - 256 : b;
      3'b001:  return (h >= 32768) ? h - 65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic bit err_model(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int unsigned size;
    if (a >= 32'd128) return 1'b1;
    if (we) begin
      if (f3 > 3'd2) return 1'b1;
      size = 1 << f3;
    end else begin
      if (f3 == 3'd3 || f3 >= 3'd6) return 1'b1;
      size = 1 << f3[1:0];
    end
    return (a % size) != 0;
  endfunction

  task automatic accept(input int unsigned e);
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a, d, w, mask;
    we = bus.REQ_WE; f3 = bus.REQ_FUNCT3; a = bus.REQ_ADDR; d = bus.REQ_WDATA;
    acc_edge = e;
    if (err_model(we, f3, a)) begin
      rsp_q.push_back('{e, 32'h0, 1'b1});
      ready_at = e + 1;
    end else if (!we) begin
      rsp_q.push_back('{e + 1, load_model(f3, a), 1'b0});
      ready_at = e + 2;
    end else if (f3 == 3'd2) begin
      wr_q.push_back('{e, a / 4, d});
      cm_q.push_back('{e, a / 4, d});
      rsp_q.push_back('{e + 1, 32'h0, 1'b0});
      ready_at = e + 2;
    end else begin
      mask = (f3 == 3'd0) ? 32'hFF : 32'hFFFF;
      w = sh[a[6:2]];
      w = (w & ~(mask << (8 * a[1:0]))) | ((d & mask) << (8 * a[1:0]));
      wr_q.push_back('{e + 1, a / 4, w});
      cm_q.push_back('{e + 1, a / 4, w});
      rsp_q.push_back('{e + 2, 32'h0, 1'b0});
      ready_at = e + 3;
    end
  endtask

  always @(posedge clk) begin
    int unsigned e;
    e = cyc + 1;
    if (cm_q.size() > 0 && cm_q[0].cyc == cyc) begin
      sh[cm_q[0].a[4:0]] = cm_q[0].d;
      void'(cm_q.pop_front());
    end
    if (rst) begin
      rsp_q.delete(); wr_q.delete(); cm_q.delete();
      ready_at = e;
    end else if (bus.REQ_VALID && cyc >= ready_at) begin
      accept(e);
    end
    cyc = e;
  end

  // ---------------- per-cycle compare ----------------
  int unsigned last_rv_cyc = 0;
  int unsigned we_count = 0;

  always @(negedge clk) begin
    bit exp_rv, exp_we;
    if (bus.RSP_VALID === 1'b1) last_rv_cyc = cyc;
    if (bus.MEM_WE === 1'b1) we_count++;
    if (chk_on) begin
      while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) void'(rsp_q.pop_front());
      while (wr_q.size() > 0 && wr_q[0].cyc < cyc) void'(wr_q.pop_front());
      chk("req_ready", {31'h0, bus.REQ_READY}, {31'h0, cyc >= ready_at});
      exp_rv = rsp_q.size() > 0 && rsp_q[0].cyc == cyc;
      chk("rsp_valid", {31'h0, bus.RSP_VALID}, {31'h0, exp_rv});
      if (exp_rv) begin
        chk("rsp_data", bus.RSP_DATA, rsp_q[0].data);
        chk("rsp_err", {31'h0, bus.RSP_ERR}, {31'h0, rsp_q[0].err});
        void'(rsp_q.pop_front());
      end
      exp_we = wr_q.size() > 0 && wr_q[0].cyc == cyc;
      chk("mem_we", {31'h0, bus.MEM_WE}, {31'h0, exp_we});
      if (exp_we) begin
        chk("mem_a", bus.MEM_A, wr_q[0].a);
        chk("mem_wd", bus.MEM_WD, wr_q[0].d);
        void'(wr_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic junk_inputs();
    bus.REQ_WE = 1'b1; bus.REQ_FUNCT3 = 3'b111;
    bus.REQ_ADDR = 32'hFFFF_FFFF; bus.REQ_WDATA = 32'h55AA_55AA;
  endtask

  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input bit keep);
    bit done;
    done = 1'b0;
    @(negedge clk);
    bus.REQ_VALID = 1'b1; bus.REQ_WE = we; bus.REQ_FUNCT3 = f3;
    bus.REQ_ADDR = a; bus.REQ_WDATA = d;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk);
      #1;
      if (acc_edge == cyc) done = 1'b1;
    end
    if (!done) chk("accept_timeout", 32'h0, 32'h1);
    if (!keep) begin
      @(negedge clk);
      bus.REQ_VALID = 1'b0;
      junk_inputs();
    end
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 20 && !idle; i++) begin
      @(negedge clk);
      #1;
      idle = rsp_q.size() == 0 && wr_q.size() == 0 && cyc >= ready_at;
    end
    if (!idle) chk("idle_timeout", 32'h0, 32'h1);
  endtask

  task automatic load_chk(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] exp);
    req(1'b0, f3, a, 32'h0, 1'b0);
    wait_idle();
    chk(name, bus.RSP_DATA, exp);
  endtask

  int unsigned a0, a1, a2, we0;

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = 32'h1000_0000 + i;
      sh[i]  = 32'h1000_0000 + i;
    end
    bus.REQ_VALID = 1'b0;
    junk_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    chk("rst_ready", {31'h0, bus.REQ_READY}, 32'h1);
    chk("rst_rsp_valid", {31'h0, bus.RSP_VALID}, 32'h0);
    chk("rst_rsp_data", bus.RSP_DATA, 32'h0);
    chk("rst_rsp_err", {31'h0, bus.RSP_ERR}, 32'h0);
    chk("rst_mem_we", {31'h0, bus.MEM_WE}, 32'h0);
    chk("rst_mem_a", bus.MEM_A, 32'h0);
    chk("rst_mem_wd", bus.MEM_WD, 32'h0);

    // SW: one write cycle, response sampled two edges after accept.
    we0 = we_count;
    req(1'b1, 3'b010, 32'h08, 32'hDEAD_BEEF, 1'b0);
    a0 = acc_edge;
    wait_idle();
    chk("sw_latency", last_rv_cyc - a0 + 1, 32'd2);
    chk("sw_we_cycles", we_count - we0, 32'd1);
    chk("sw_mem", mem[2], 32'hDEAD_BEEF);
    chk("sw_err", {31'h0, bus.RSP_ERR}, 32'h0);

    // Loads from word2 = 0x8899AABB.
    req(1'b1, 3'b010, 32'h08, 32'h8899_AABB, 1'b0);
    wait_idle();
    load_chk("lb_09",  3'b000, 32'h09, 32'hFFFF_FFAA);
    load_chk("lbu_0b", 3'b100, 32'h0B, 32'h0000_0088);
    load_chk("lh_0a",  3'b001, 32'h0A, 32'hFFFF_8899);
    load_chk("lhu_08", 3'b101, 32'h08, 32'h0000_AABB);
    load_chk("lw_08",  3'b010, 32'h08, 32'h8899_AABB);

    // Sub-word stores via read-modify-write.
    we0 = we_count;
    req(1'b1, 3'b000, 32'h09, 32'h1234_5677, 1'b0);
    a0 = acc_edge;
    wait_idle();
    chk("sb_latency", last_rv_cyc - a0 + 1, 32'd3);
    chk("sb_we_cycles", we_count - we0, 32'd1);
    chk("sb_mem", mem[2], 32'h8899_77BB);
    req(1'b1, 3'b010, 32'h08, 32'h8899_AABB, 1'b0);
    wait_idle();
    req(1'b1, 3'b001, 32'h0A, 32'h0000_CAFE, 1'b0);
    wait_idle();
    chk("sh_mem", mem[2], 32'hCAFE_AABB);

    // Rejected requests: one-cycle error response, memory untouched.
    we0 = we_count;
    req(1'b0, 3'b010, 32'h06, 32'h0, 1'b0);
    a0 = acc_edge;
    wait_idle();
    chk("err_latency", last_rv_cyc - a0 + 1, 32'd1);
    chk("err_lw06", {31'h0, bus.RSP_ERR}, 32'h1);
    req(1'b1, 3'b001, 32'h03, 32'hFFFF_FFFF, 1'b0);
    wait_idle();
    chk("err_sh03", {31'h0, bus.RSP_ERR}, 32'h1);
    req(1'b0, 3'b011, 32'h08, 32'h0, 1'b0);
    wait_idle();
    chk("err_f3_011", {31'h0, bus.RSP_ERR}, 32'h1);
    req(1'b0, 3'b010, 32'h80, 32'h0, 1'b0);
    wait_idle();
    chk("err_range", {31'h0, bus.RSP_ERR}, 32'h1);
    chk("err_data", bus.RSP_DATA, 32'h0);
    chk("err_no_we", we_count - we0, 32'd0);

    // Reset during the read half of an SB abandons the write.
    we0 = we_count;
    req(1'b1, 3'b000, 32'h08, 32'h0000_0011, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ready", {31'h0, bus.REQ_READY}, 32'h1);
    chk("rst_mid_mem_a", bus.MEM_A, 32'h0);
    chk("rst_mid_no_we", we_count - we0, 32'd0);
    load_chk("rst_readback", 3'b010, 32'h08, 32'hCAFE_AABB);

    // Back-to-back loads with REQ_VALID held high.
    req(1'b0, 3'b010, 32'h00, 32'h0, 1'b1);
    a0 = acc_edge;
    req(1'b0, 3'b010, 32'h04, 32'h0, 1'b1);
    a1 = acc_edge;
    req(1'b0, 3'b010, 32'h08, 32'h0, 1'b0);
    a2 = acc_edge;
    wait_idle();
    chk("b2b_gap1", a1 - a0, 32'd3);
    chk("b2b_gap2", a2 - a1, 32'd3);
    chk("b2b_last", bus.RSP_DATA, 32'hCAFE_AABB);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
